fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: buffers ray pixel writes in a small FIFO and
// interleaves them with full-frame clears. Optional FB_DROP_COUNT_EN adds a drop counter.
module fb_write_arbiter #(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ray_valid,
  output logic        ray_ready,
  input  logic [15:0] ray_x,
  input  logic [15:0] ray_y,
  input  logic [15:0] ray_pixel,
  input  logic        clear_start,
  input  logic [11:0] clear_color,
  output logic        clear_busy,
  output logic        clear_done,
`ifdef FB_DROP_COUNT_EN
  output logic [15:0] drop_count,
`endif
  output logic        bram_we,
  output logic [17:0] bram_addr,
  output logic [15:0] bram_din
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
  localparam logic [17:0] LAST  = 18'(TOTAL - 1);
  localparam logic [17:0] FW18  = 18'(FRAME_WIDTH);
  localparam logic [16:0] FW17  = 17'(FRAME_WIDTH);
  localparam logic [16:0] FH17  = 17'(FRAME_HEIGHT);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] din;
  } wr_t;

  state_t      state_q, state_d;
  wr_t         mem_q [FIFO_DEPTH];
  wr_t         p1_q;
  logic        p1_vld_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        rdy_q, done_q, done_d, we_q, we_d;
  logic [17:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [15:0] din_q, din_d;
  logic [11:0] color_q, color_d;

  logic        full, empty, in_range, accept, push, pop, flush;
  logic [17:0] lin_addr;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign ray_ready  = rdy_q & ~full;
  assign accept     = ray_valid & ray_ready;
  assign in_range   = ({1'b0, ray_x} < FW17) && ({1'b0, ray_y} < FH17);
  assign push       = accept & in_range;
  assign lin_addr   = {2'b0, ray_y} * FW18 + {2'b0, ray_x};
  assign flush      = (state_q == IDLE) && clear_start;
  // Draining is held off through the clear_done cycle so it resumes the cycle after.
  assign pop        = (state_q == IDLE) && !empty && !clear_start && !done_q;

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = done_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p1_vld_q) begin
          we_d   = 1'b1;
          addr_d = p1_q.addr;
          din_d  = p1_q.din;
        end
        if (clear_start) begin
          state_d = CLEAR;
          color_d = clear_color;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = {4'b0, color_q};
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{addr: lin_addr, din: ray_pixel};
    if (pop)  p1_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      p1_vld_q <= 1'b0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      cnt_q    <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      color_q  <= color_d;
      p1_vld_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      // A flush drops everything queued before this cycle; a same-cycle push survives.
      if (flush)    rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_q;
  assign drop_count = drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              drop_q <= '0;
    else if (accept && !in_range && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a 512x4 frame so full clears stay short.
module tb_fb_write_arbiter;
  localparam int FW = 512;
  localparam int FH = 4;
  localparam int TOTAL = FW * FH;

  logic        clk = 1'b0;
  logic        rst_n, ray_valid, ray_ready, clear_start, clear_busy, clear_done;
  logic [15:0] ray_x, ray_y, ray_pixel;
  logic [11:0] clear_color;
  logic        bram_we;
  logic [17:0] bram_addr;
  logic [15:0] bram_din;
`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  fb_write_arbiter #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_x(ray_x), .ray_y(ray_y), .ray_pixel(ray_pixel),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
`ifdef FB_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t wlog[$];
  int  cyc = 0, done_cnt = 0, done_cyc = 0;
  int  chk = 0, pass = 0;

  always @(posedge clk) begin
    if (bram_we === 1'b1) wlog.push_back('{bram_addr, bram_din, cyc});
    if (clear_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic set_px(input int x, input int y, input logic [15:0] p);
    ray_valid = 1'b1; ray_x = 16'(x); ray_y = 16'(y); ray_pixel = p;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk++; if (ray_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ray_ready); else pass++;
    chk++; if (bram_we !== 1'b0) $display("FAIL rst_we got %b want 0", bram_we); else pass++;
    chk++; if (bram_addr !== 18'd0 || bram_din !== 16'd0)
      $display("FAIL rst_addr_din got %h/%h want 0/0", bram_addr, bram_din); else pass++;
    chk++; if (clear_busy !== 1'b0 || clear_done !== 1'b0)
      $display("FAIL rst_clear got %b%b want 00", clear_busy, clear_done); else pass++;
`ifdef FB_DROP_COUNT_EN
    chk++; if (drop_count !== 16'd0) $display("FAIL rst_drop got %0d want 0", drop_count); else pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk++; if (ray_ready !== 1'b1) $display("FAIL ready_after_rst got %b want 1", ray_ready); else pass++;
  endtask

  task automatic test_single;
    wlog.delete();
    @(negedge clk); set_px(3, 2, 16'h0ABC);
    @(negedge clk); ray_valid = 1'b0;
    chk++; if (bram_we !== 1'b0) $display("FAIL single_lat1 got %b want 0", bram_we); else pass++;
    @(negedge clk);
    chk++; if (bram_we !== 1'b0) $display("FAIL single_lat1b got %b want 0", bram_we); else pass++;
    @(negedge clk);
    chk++; if (bram_we !== 1'b1 || bram_addr !== 18'd1027 || bram_din !== 16'h0ABC)
      $display("FAIL single_write got we=%b addr=%0d din=%h want 1/1027/0abc", bram_we, bram_addr, bram_din);
    else pass++;
    @(negedge clk);
    chk++; if (bram_we !== 1'b0) $display("FAIL single_we_drop got %b want 0", bram_we); else pass++;
  endtask

  task automatic test_drop;
    wlog.delete();
    @(negedge clk); set_px(512, 0, 16'h0111);
    @(negedge clk); set_px(0, 4, 16'h0222);
`ifdef FB_DROP_COUNT_EN
    chk++; if (drop_count !== 16'd1) $display("FAIL drop_cnt1 got %0d want 1", drop_count); else pass++;
`endif
    @(negedge clk); set_px(511, 3, 16'h0777);
    @(negedge clk); ray_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk++; if (wlog.size() !== 1) $display("FAIL drop_writes got %0d want 1", wlog.size()); else pass++;
    chk++; if (wlog.size() < 1 || wlog[0].a !== 18'd2047 || wlog[0].d !== 16'h0777)
      $display("FAIL drop_corner got size %0d want addr 2047 din 0777", wlog.size()); else pass++;
`ifdef FB_DROP_COUNT_EN
    chk++; if (drop_count !== 16'd2) $display("FAIL drop_cnt2 got %0d want 2", drop_count); else pass++;
`endif
  endtask

  task automatic test_back_to_back;
    int bad;
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_px(i * 5, 3, 16'h3000 + 16'(i));
    end
    @(negedge clk); ray_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk++; if (wlog.size() !== 4) $display("FAIL b2b_count got %0d want 4", wlog.size()); else pass++;
    bad = 0;
    foreach (wlog[i])
      if (wlog[i].a !== 18'(1536 + 5 * i) || wlog[i].d !== 16'h3000 + 16'(i) || wlog[i].c !== wlog[0].c + i) bad++;
    chk++; if (bad != 0) $display("FAIL b2b_stream got %0d bad want 0", bad); else pass++;
  endtask

  task automatic test_clear;
    int n, bad, d0;
    wlog.delete(); d0 = done_cnt;
    @(negedge clk); clear_color = 12'h0F0; clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0; clear_color = 12'hABC;
    chk++; if (clear_busy !== 1'b1) $display("FAIL clear_busy_rise got %b want 1", clear_busy); else pass++;
    repeat (100) @(negedge clk);
    clear_start = 1'b1; clear_color = 12'h00F;
    @(negedge clk); clear_start = 1'b0;
    n = 0;
    while (clear_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk++; if (clear_done !== 1'b1) $display("FAIL clear_done_seen got 0 want 1"); else pass++;
    chk++; if (clear_busy !== 1'b0) $display("FAIL clear_busy_fall got %b want 0", clear_busy); else pass++;
    @(negedge clk);
    chk++; if (clear_done !== 1'b0) $display("FAIL clear_done_pulse got %b want 0", clear_done); else pass++;
    repeat (5) @(negedge clk);
    chk++; if (done_cnt - d0 != 1) $display("FAIL clear_done_count got %0d want 1", done_cnt - d0); else pass++;
    chk++; if (wlog.size() != TOTAL) $display("FAIL clear_writes got %0d want %0d", wlog.size(), TOTAL); else pass++;
    bad = 0;
    foreach (wlog[i])
      if (wlog[i].a !== 18'(i) || wlog[i].d !== 16'h00F0 || wlog[i].c !== wlog[0].c + i) bad++;
    chk++; if (bad != 0) $display("FAIL clear_sequence got %0d bad want 0", bad); else pass++;
  endtask

  task automatic test_clear_fifo;
    int n, idx, d0, bad;
    bit acc, saw;
    wr_t pw[$];
    wlog.delete(); d0 = done_cnt; idx = 0; saw = 0; n = 0;
    @(negedge clk); clear_color = 12'h111; clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0; set_px(10, 1, 16'h1000);
    while (idx < 6 && n < 5000) begin
      if (!saw && idx == 4 && clear_busy === 1'b1) begin
        saw = 1;
        chk++; if (ray_ready !== 1'b0) $display("FAIL fifo_full_ready got %b want 0", ray_ready); else pass++;
      end
      acc = (ray_valid && ray_ready === 1'b1);
      @(negedge clk); n++;
      if (acc) begin
        idx++;
        if (idx < 6) set_px(10 + idx, 1, 16'h1000 + 16'(idx));
        else ray_valid = 1'b0;
      end
    end
    ray_valid = 1'b0;
    chk++; if (idx != 6 || !saw) $display("FAIL fifo_accepts got %0d saw_full %0d want 6 1", idx, saw); else pass++;
    repeat (10) @(negedge clk);
    foreach (wlog[i]) if (wlog[i].d[15:12] == 4'h1) pw.push_back(wlog[i]);
    chk++; if (pw.size() != 6) $display("FAIL fifo_pix_writes got %0d want 6", pw.size()); else pass++;
    bad = 0;
    foreach (pw[i]) if (pw[i].a !== 18'(522 + i) || pw[i].d !== 16'h1000 + 16'(i)) bad++;
    chk++; if (bad != 0) $display("FAIL fifo_order got %0d bad want 0", bad); else pass++;
    chk++; if (pw.size() < 1 || pw[0].c <= done_cyc || done_cnt - d0 != 1)
      $display("FAIL fifo_after_done got first %0d done %0d want later", pw.size() ? pw[0].c : -1, done_cyc);
    else pass++;
  endtask

  task automatic test_flush;
    int n, bad, hits, d0;
    wlog.delete(); d0 = done_cnt;
    @(negedge clk); clear_color = 12'h222; clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_px(20 + i, 0, 16'h2000 + 16'(i)); @(negedge clk);
    end
    ray_valid = 1'b0;
    n = 0;
    while (clear_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk++; if (ray_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", ray_ready); else pass++;
    clear_color = 12'h333; clear_start = 1'b1; set_px(30, 0, 16'h2ABC);
    @(negedge clk); clear_start = 1'b0; ray_valid = 1'b0;
    n = 0;
    while (clear_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    bad = 0; hits = 0;
    foreach (wlog[i]) begin
      if (wlog[i].d >= 16'h2000 && wlog[i].d <= 16'h2002) bad++;
      if (wlog[i].d === 16'h2ABC && wlog[i].a === 18'd30 && wlog[i].c > done_cyc) hits++;
    end
    chk++; if (bad != 0) $display("FAIL flush_stale got %0d writes want 0", bad); else pass++;
    chk++; if (hits != 1 || done_cnt - d0 != 2)
      $display("FAIL flush_retained got %0d writes %0d dones want 1 2", hits, done_cnt - d0); else pass++;
  endtask

  task automatic test_reset_mid_clear;
    int n, d0;
    @(negedge clk); clear_color = 12'h444; clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0;
    n = 0;
    while (!(bram_we === 1'b1 && bram_addr === 18'd1000) && n < 3000) begin @(negedge clk); n++; end
    chk++; if (bram_addr !== 18'd1000) $display("FAIL mid_reach got %0d want 1000", bram_addr); else pass++;
    rst_n = 1'b0; d0 = done_cnt;
    #1;
    chk++; if ({bram_we, bram_addr, bram_din, clear_busy, clear_done, ray_ready} !== '0)
      $display("FAIL mid_rst_outs got we=%b a=%0d d=%h busy=%b done=%b rdy=%b want all 0",
               bram_we, bram_addr, bram_din, clear_busy, clear_done, ray_ready);
    else pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk++; if (done_cnt != d0) $display("FAIL mid_no_done got %0d want %0d", done_cnt, d0); else pass++;
    wlog.delete();
    clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0;
    n = 0;
    while (clear_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk++; if (wlog.size() != TOTAL || wlog[0].a !== 18'd0 || wlog[0].d !== 16'h0444)
      $display("FAIL mid_restart got size %0d first %0d want %0d 0", wlog.size(), wlog.size() ? wlog[0].a : 0, TOTAL);
    else pass++;
  endtask

  initial begin
    rst_n = 1'b0; ray_valid = 1'b0; ray_x = '0; ray_y = '0; ray_pixel = '0;
    clear_start = 1'b0; clear_color = '0;
    test_reset();
    test_single();
    test_drop();
    test_back_to_back();
    test_clear();
    test_clear_fifo();
    test_flush();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
